// File: rtl/iomem_initiator.sv
// iomem_initiator: bus-master side of the iomem valid/ready port.
// One aligned word transaction per accepted LSU request, with timeout.
module iomem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [1:0]  resp_err_o,
    output logic [15:0] last_latency_o,
    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [31:0] iomem_addr_o,
    output logic [3:0]  iomem_wstrb_o,
    output logic [31:0] iomem_wdata_o,
    input  logic [31:0] iomem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lat_q, lat_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    logic        misaligned;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign req_ready_o    = (state_q == IDLE);
    assign iomem_valid_o  = valid_q;
    assign iomem_addr_o   = addr_q;
    assign iomem_wstrb_o  = wstrb_q;
    assign iomem_wdata_o  = wdata_q;
    assign resp_valid_o   = rvalid_q;
    assign resp_rdata_o   = rdata_q;
    assign resp_err_o     = err_q;
    assign last_latency_o = lat_q;

    // Request decode: alignment check, byte-lane strobes, data replication.
    always_comb begin
        misaligned = 1'b0;
        strb_new   = 4'b0000;
        wdata_new  = req_wdata_i;
        unique case (req_size_i)
            2'd0: begin
                strb_new  = 4'b0001 << req_addr_i[1:0];
                wdata_new = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = req_addr_i[0];
                strb_new   = 4'b0011 << req_addr_i[1:0];
                wdata_new  = {2{req_wdata_i[15:0]}};
            end
            2'd2: begin
                misaligned = (req_addr_i[1:0] != 2'b00);
                strb_new   = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
        if (!req_we_i) begin
            strb_new = 4'b0000;
        end
    end

    // Load path: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        lane     = iomem_rdata_i >> {off_q, 3'b000};
        load_ext = lane;
        unique case (size_q)
            2'd0: load_ext = uns_q ? {24'h0, lane[7:0]}
                                   : {{24{lane[7]}}, lane[7:0]};
            2'd1: load_ext = uns_q ? {16'h0, lane[15:0]}
                                   : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = iomem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic of the IDLE/BUS/RESP FSM.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        we_d     = we_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (misaligned) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = 32'h0;
                        err_d    = 2'b01;
                    end else begin
                        state_d = BUS;
                        valid_d = 1'b1;
                        addr_d  = {req_addr_i[31:2], 2'b00};
                        wstrb_d = strb_new;
                        wdata_d = wdata_new;
                        size_d  = req_size_i;
                        uns_d   = req_unsigned_i;
                        we_d    = req_we_i;
                        off_d   = req_addr_i[1:0];
                        cnt_d   = 16'h0;
                    end
                end
            end
            BUS: begin
                if (iomem_ready_i) begin
                    state_d  = RESP;
                    valid_d  = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? 32'h0 : load_ext;
                    err_d    = 2'b00;
                    lat_d    = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = RESP;
                    valid_d  = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = 32'h0;
                    err_d    = 2'b10;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            addr_q   <= 32'h0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            off_q    <= 2'd0;
            cnt_q    <= 16'h0;
            lat_q    <= 16'h0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            we_q     <= we_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_iomem_initiator.sv
// tb_iomem_initiator: directed and random requests against a
// behavioural responder and reference model.
module tb_iomem_initiator;

    localparam int TO = 64;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic [1:0]  resp_err_o;
    logic [15:0] last_latency_o;
    logic        iomem_valid_o;
    logic        iomem_ready_i = 1'b0;
    logic [31:0] iomem_addr_o;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_wdata_o;
    logic [31:0] iomem_rdata_i = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_lat  = 0;

    iomem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .last_latency_o (last_latency_o),
        .iomem_valid_o  (iomem_valid_o),
        .iomem_ready_i  (iomem_ready_i),
        .iomem_addr_o   (iomem_addr_o),
        .iomem_wstrb_o  (iomem_wstrb_o),
        .iomem_wdata_o  (iomem_wdata_o),
        .iomem_rdata_i  (iomem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_valid"}, 32'(iomem_valid_o), 32'h0);
        chk({tag, "_addr"}, iomem_addr_o, 32'h0);
        chk({tag, "_wstrb"}, 32'(iomem_wstrb_o), 32'h0);
        chk({tag, "_wdata"}, iomem_wdata_o, 32'h0);
        chk({tag, "_rvalid"}, 32'(resp_valid_o), 32'h0);
        chk({tag, "_rdata"}, resp_rdata_o, 32'h0);
        chk({tag, "_err"}, 32'(resp_err_o), 32'h0);
        chk({tag, "_lat"}, 32'(last_latency_o), 32'h0);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'h1);
    endtask

    // delay < 0: responder never answers; else ready after delay cycles.
    task automatic run_req(input string tag, input bit we,
                           input logic [31:0] addr, input logic [1:0] size,
                           input bit uns, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay);
        int off;
        bit mis, tout;
        int exp_nv, exp_err, vcnt, rcyc, bad;
        logic [31:0] e_addr, e_wd, e_rd, lane;
        logic [3:0]  e_strb;
        bit got;
        off  = int'(addr % 4);
        mis  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
            || (size == 2'd2 && off != 0);
        tout = !mis && (delay < 0 || delay >= TO);
        exp_nv  = mis ? 0 : (tout ? TO : delay + 1);
        exp_err = mis ? 1 : (tout ? 2 : 0);
        e_addr = addr - 32'(off);
        case (size)
            2'd0: begin e_strb = 4'(1 << off); e_wd = (wd % 256) * 32'h01010101; end
            2'd1: begin e_strb = 4'(3 << off); e_wd = (wd % 65536) * 32'h00010001; end
            default: begin e_strb = 4'hF; e_wd = wd; end
        endcase
        if (!we) e_strb = 4'h0;
        lane = rd >> (8 * off);
        e_rd = 32'h0;
        if (!we && exp_err == 0) begin
            case (size)
                2'd0: e_rd = (lane % 256 >= 128 && !uns) ? (lane % 256) - 256
                                                          : lane % 256;
                2'd1: e_rd = (lane % 65536 >= 32768 && !uns) ? (lane % 65536) - 65536
                                                              : lane % 65536;
                default: e_rd = rd;
            endcase
        end
        req_we_i = we;
        req_addr_i = addr;
        req_size_i = size;
        req_unsigned_i = uns;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        chk({tag, "_reqrdy"}, 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = 1'b0;
        vcnt = 0; rcyc = -1; bad = 0; got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (iomem_valid_o) begin
                if (iomem_addr_o !== e_addr || iomem_wstrb_o !== e_strb
                    || iomem_wdata_o !== e_wd) bad++;
                iomem_ready_i = (delay >= 0 && vcnt == delay);
                iomem_rdata_i = iomem_ready_i ? rd : $urandom;
                vcnt++;
            end else begin
                iomem_ready_i = 1'b0;
                if (resp_valid_o) begin
                    got = 1;
                    rcyc = c;
                end
            end
            if (!got) step();
        end
        chk({tag, "_gotresp"}, 32'(got), 32'h1);
        chk({tag, "_nvalid"}, 32'(vcnt), 32'(exp_nv));
        chk({tag, "_resptime"}, 32'(rcyc), 32'(exp_nv));
        chk({tag, "_busstable"}, 32'(bad), 32'h0);
        chk({tag, "_err"}, 32'(resp_err_o), 32'(exp_err));
        chk({tag, "_rdata"}, resp_rdata_o, e_rd);
        if (exp_err == 0) exp_lat = delay;
        chk({tag, "_lat"}, 32'(last_latency_o), 32'(exp_lat));
        step();
        chk({tag, "_pulse1"}, 32'(resp_valid_o), 32'h0);
        chk({tag, "_backrdy"}, 32'(req_ready_o), 32'h1);
    endtask

    initial begin
        int d;
        logic [31:0] a;
        logic [1:0]  sz;
        step();
        step();
        chk_idle_reset("reset");
        rst_n = 1'b1;
        step();

        run_req("ldw_zw", 0, 32'h3000_0000, 2'd2, 0, 0, 32'h0000_1234, 0);
        run_req("stb_ram", 1, 32'h4000_0003, 2'd0, 0, 32'h0000_00A5, 0, 17);
        run_req("ldh_s", 0, 32'h4000_0002, 2'd1, 0, 0, 32'h8001_0000, 3);
        run_req("ldh_u", 0, 32'h4000_0002, 2'd1, 1, 0, 32'h8001_0000, 1);
        run_req("ldb_s", 0, 32'h4000_0001, 2'd0, 0, 0, 32'h0000_7F00, 2);
        run_req("ldb_neg", 0, 32'h4000_0003, 2'd0, 0, 0, 32'h8000_0000, 0);
        run_req("mis_w", 0, 32'h4000_0002, 2'd2, 0, 0, 32'hDEAD_BEEF, 0);
        run_req("mis_sz3", 1, 32'h4000_0000, 2'd3, 0, 32'h1, 0, 0);
        run_req("mis_h", 0, 32'h4000_0001, 2'd1, 0, 0, 0, 0);
        run_req("sth", 1, 32'h4000_0002, 2'd1, 0, 32'hFFFF_BEEF, 0, 5);
        run_req("tout", 0, 32'h3000_0004, 2'd2, 0, 0, 32'h1111_1111, -1);

        step();
        iomem_ready_i = 1'b1;
        iomem_rdata_i = 32'hCAFE_F00D;
        step();
        iomem_ready_i = 1'b0;
        chk("spur_valid", 32'(iomem_valid_o), 32'h0);
        chk("spur_rvalid", 32'(resp_valid_o), 32'h0);
        chk("spur_ready", 32'(req_ready_o), 32'h1);
        step();
        chk("spur_rvalid2", 32'(resp_valid_o), 32'h0);
        run_req("after_spur", 0, 32'h3000_0008, 2'd2, 0, 0, 32'h5A5A_0001, 4);

        req_we_i = 1'b0;
        req_addr_i = 32'h4000_0010;
        req_size_i = 2'd2;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("mid_valid", 32'(iomem_valid_o), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_reset("midrst");
        exp_lat = 0;
        iomem_ready_i = 1'b1;
        step();
        iomem_ready_i = 1'b0;
        chk("late_rvalid", 32'(resp_valid_o), 32'h0);
        chk("late_valid", 32'(iomem_valid_o), 32'h0);
        step();
        chk("late_rvalid2", 32'(resp_valid_o), 32'h0);

        for (int i = 0; i < 40; i++) begin
            a  = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
            if ($urandom_range(0, 7) == 0) begin
                d = -1;
            end else begin
                d = int'($urandom_range(0, 20));
            end
            run_req("rnd", 1'($urandom), a, sz, 1'($urandom),
                    $urandom, $urandom, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_initiator.md
# iomem_initiator

Bus-master end of the iomem valid/ready interface. Accepts single load/store requests from the core's load-store stage, issues exactly one aligned iomem word transaction per accepted request, and returns the load result or store acknowledgement. It handles byte-lane steering, misalignment rejection and a ready timeout, and it measures per-transaction latency. It sits inside user_processor between the LSU and the iomem_* ports.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles iomem_valid_o stays high without iomem_ready_i before the transaction is aborted; legal range 2..65535.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_i  in  1  zero-extend loads (else sign-extend).
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle response pulse; no backpressure.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  2  00 ok, 01 misaligned/illegal size, 10 timeout.
- last_latency_o  out  16  latency of the last completed bus transaction.
- iomem_valid_o  out  1  bus request.
- iomem_ready_i  in  1  responder completion.
- iomem_addr_o  out  32  {req_addr_i[31:2], 2'b00}.
- iomem_wstrb_o  out  4  byte enables; 0 for loads.
- iomem_wdata_o  out  32  lane-replicated store data.
- iomem_rdata_i  in  32  read data, valid in the completion cycle.

## Operation
- States: IDLE, BUS, RESP. req_ready_o = 1 only in IDLE.
- IDLE, accept: check alignment. Misaligned = size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3. If misaligned -> RESP with err 01, no bus activity. Else register addr, wstrb, wdata, size, unsigned, and byte offset -> BUS.
- wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; forced 0 when req_we_i=0.
- wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as is.
- BUS: iomem_valid_o=1; addr/wstrb/wdata held stable. Latency counter cnt starts at 0 in the first BUS cycle and increments each BUS cycle.
  - iomem_ready_i=1: completion. Capture iomem_rdata_i; last_latency_o<=cnt -> RESP with err 00.
  - iomem_ready_i=0 and cnt==TIMEOUT_CYCLES-1 -> abort -> RESP with err 10; last_latency_o unchanged.
- RESP: resp_valid_o=1 for one cycle, then IDLE. Load data: lane = rdata >> (8*offset); byte/half sign- or zero-extended, word unchanged. Stores and errors return 0.
- iomem_ready_i is ignored outside BUS. Responders may pulse ready while valid is low, e.g. a stale delay pipe after an abort; such a pulse must not complete or corrupt anything.
- Wrap-around: cnt saturates at 16'hFFFF, which is unreachable with legal TIMEOUT_CYCLES.

## Timing
- Reset (rst_n low at an edge, in any state including mid-BUS): next cycle state=IDLE, iomem_valid_o=0, iomem_addr_o=0, iomem_wstrb_o=0, iomem_wdata_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, last_latency_o=0, req_ready_o=1. An in-flight transaction is dropped silently.
- All outputs are registered except req_ready_o, which is decoded from state.
- Request accepted at edge A: iomem_valid_o is high from cycle A+1.
- Completion cycle N (valid & ready): iomem_valid_o=0 and resp_valid_o=1 in N+1; req_ready_o=1 in N+2. iomem_valid_o is therefore low for at least 2 cycles between transactions.
- Zero-wait responder (ready in the first BUS cycle): accept to resp_valid = 2 cycles, last_latency_o = 0.
- RAM responder with a 16-stage ready delay: ready at cnt=17, last_latency_o=17.
- Misaligned request: resp_valid_o in the cycle after acceptance; iomem_valid_o never rises.
- Timeout: iomem_valid_o is high for exactly TIMEOUT_CYCLES cycles; resp_valid_o follows in the next cycle.

## Test plan
- Load word 0x3000_0000 against a zero-wait responder returning 0x0000_1234 -> iomem_valid_o high 1 cycle, wstrb 0, resp_rdata_o 0x0000_1234, err 00, last_latency_o 0.
- Store byte 0xA5 to 0x4000_0003 against a 16-delay RAM responder -> iomem_addr_o 0x4000_0000, wstrb 4'b1000, wdata 0xA5A5A5A5 stable until ready, last_latency_o 17, err 00.
- Load half signed from 0x4000_0002 with rdata 0x8001_0000 -> resp_rdata_o 0xFFFF_8001; the same load unsigned -> 0x0000_8001; load byte signed from offset 1 with rdata 0x0000_7F00 -> 0x0000_007F.
- Load word from 0x4000_0002 and a size-3 request -> err 01, iomem_valid_o stays 0, response one cycle after acceptance.
- Load 0x3000_0004 against a responder that never asserts ready, TIMEOUT_CYCLES=64 -> valid high exactly 64 cycles, err 10, last_latency_o unchanged; a spurious ready pulse 3 cycles later is ignored and the next request completes normally.
- rst_n low for 1 cycle at cnt=5 of a RAM load -> iomem_valid_o 0 next cycle, no resp_valid_o, req_ready_o 1; a late ready pulse from the responder is ignored.
